// File: rtl/uart_receiver_pkg.sv
// Shared types for the UART receive path: FSM state encoding and the majority helper.
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_receiver_rx_sync_vote.sv
// Two-flop synchroniser for an asynchronous input, followed by a 3-deep history
// that supplies a majority-voted sample and a clean falling-edge strobe.
module rx_sync_vote
    import uart_receiver_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall,
    output logic vote
);

    logic       sync_a;
    logic       sync_b;
    logic [2:0] hist;
    logic [1:0] fill;

    // The history only starts tracking once the synchroniser holds real line
    // samples, so a line held low through reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            hist   <= 3'b000;
            fill   <= 2'b00;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
            fill   <= {fill[0], 1'b1};
            if (fill[1]) begin
                hist <= {hist[1:0], sync_b};
            end
        end
    end

    assign level = sync_b;
    assign fall  = hist[0] & ~sync_b;
    assign vote  = maj3(hist);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit qualification, mid-bit majority sampling and a
// level-held byte interface with sticky framing/overrun flags.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLOCK_HZ  = 27_000_000,
    parameter int BAUD      = 115200,
    parameter int TIM_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun,
    output logic       dbg_rx_timing
);

    localparam int DIV  = CLOCK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam logic [TIM_WIDTH-1:0] DIV_M1  = TIM_WIDTH'(DIV - 1);
    localparam logic [TIM_WIDTH-1:0] HALF_M1 = TIM_WIDTH'(HALF - 1);

    if ((DIV - 1) >= (2 ** TIM_WIDTH) || DIV < 8) begin : g_bad_div
        $error("uart_receiver: DIV out of range for TIM_WIDTH");
    end

    logic line_level;
    logic line_fall;
    logic line_vote;

    rx_sync_vote u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rx),
        .level (line_level),
        .fall  (line_fall),
        .vote  (line_vote)
    );

    rx_state_t             state;
    logic [TIM_WIDTH-1:0]  timer;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;

    // Later assignments in this block deliberately override earlier ones:
    // a completing byte beats rd, and a new error beats clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            rx_full       <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
            dbg_rx_timing <= 1'b0;
        end else begin
            dbg_rx_timing <= 1'b0;
            if (rd) begin
                rx_full <= 1'b0;
            end
            if (clr_err) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (line_fall) begin
                        timer <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (timer == HALF_M1) begin
                        dbg_rx_timing <= 1'b1;
                        timer         <= '0;
                        bit_idx       <= '0;
                        state         <= line_vote ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == DIV_M1) begin
                        dbg_rx_timing <= 1'b1;
                        timer         <= '0;
                        shreg         <= {line_vote, shreg[7:1]};
                        bit_idx       <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == DIV_M1) begin
                        dbg_rx_timing <= 1'b1;
                        timer         <= '0;
                        if (line_vote) begin
                            rx_data <= shreg;
                            rx_full <= 1'b1;
                            if (rx_full && !rd) begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BREAK: begin
                    if (line_level) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
